// File: rtl/ezrisc_pkg.sv
// Shared ezRISC register-file types and sizes, used by the register bank,
// the read-select muxes and the decoder.
package ezrisc_pkg;

  localparam int unsigned REG_SIZE   = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One-hot select for a destination register; r0 never gets a select bit.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic vld, input reg_addr_t rd);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (vld) begin
      oh[rd] = 1'b1;
    end
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/reg_bank_32x32_reg_cell.sv
// Single register of the bank: async active-high reset, write enable.
module reg_cell
  import ezrisc_pkg::*;
#(
  parameter int unsigned W = REG_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: load on write enable, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = wdata;
    end
  end

  // Storage flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/reg_bank_32x32.sv
// ezRISC architectural register bank: 31 storage registers plus hardwired r0,
// one write-back port, and a per-register pending-write scoreboard (busy).
// Optional macro REG_BANK_WB_BYPASS_EN forwards wb_data combinationally onto
// the addressed output in the write cycle; busy is never bypassed.
module reg_bank_32x32
  import ezrisc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [REG_SIZE-1:0]   wb_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [REG_SIZE-1:0]   r0,
  output logic [REG_SIZE-1:0]   r1,
  output logic [REG_SIZE-1:0]   r2,
  output logic [REG_SIZE-1:0]   r3,
  output logic [REG_SIZE-1:0]   r4,
  output logic [REG_SIZE-1:0]   r5,
  output logic [REG_SIZE-1:0]   r6,
  output logic [REG_SIZE-1:0]   r7,
  output logic [REG_SIZE-1:0]   r8,
  output logic [REG_SIZE-1:0]   r9,
  output logic [REG_SIZE-1:0]   r10,
  output logic [REG_SIZE-1:0]   r11,
  output logic [REG_SIZE-1:0]   r12,
  output logic [REG_SIZE-1:0]   r13,
  output logic [REG_SIZE-1:0]   r14,
  output logic [REG_SIZE-1:0]   r15,
  output logic [REG_SIZE-1:0]   r16,
  output logic [REG_SIZE-1:0]   r17,
  output logic [REG_SIZE-1:0]   r18,
  output logic [REG_SIZE-1:0]   r19,
  output logic [REG_SIZE-1:0]   r20,
  output logic [REG_SIZE-1:0]   r21,
  output logic [REG_SIZE-1:0]   r22,
  output logic [REG_SIZE-1:0]   r23,
  output logic [REG_SIZE-1:0]   r24,
  output logic [REG_SIZE-1:0]   r25,
  output logic [REG_SIZE-1:0]   r26,
  output logic [REG_SIZE-1:0]   r27,
  output logic [REG_SIZE-1:0]   r28,
  output logic [REG_SIZE-1:0]   r29,
  output logic [REG_SIZE-1:0]   r30,
  output logic [REG_SIZE-1:0]   r31,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] wr_en;
  logic [NUM_REGS-1:0] iss_en;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [REG_SIZE-1:0] cell_q [1:NUM_REGS-1];
  logic [REG_SIZE-1:0] r_c    [0:NUM_REGS-1];

  // Write-back and issue decoders; bit 0 is always clear so r0 is never touched.
  always_comb begin
    wr_en  = rd_onehot(wb_valid, wb_rd);
    iss_en = rd_onehot(issue_valid, issue_rd);
  end

  // Storage for r1..r31.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
    reg_cell #(.W(REG_SIZE)) u_cell (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en[g]),
      .wdata (wb_data),
      .q     (cell_q[g])
    );
  end

  // Scoreboard next state: write-back clears, issue sets, issue wins on a tie.
  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (wr_en[n]) begin
        busy_d[n] = 1'b0;
      end
      if (iss_en[n]) begin
        busy_d[n] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Output values: stored contents, optionally overridden by the in-flight write.
  always_comb begin
    r_c[0] = '0;
    for (int n = 1; n < NUM_REGS; n++) begin
      r_c[n] = cell_q[n];
`ifdef REG_BANK_WB_BYPASS_EN
      if (wr_en[n]) begin
        r_c[n] = wb_data;
      end
`endif
    end
  end

  assign busy = busy_q;

  assign r0  = r_c[0];
  assign r1  = r_c[1];
  assign r2  = r_c[2];
  assign r3  = r_c[3];
  assign r4  = r_c[4];
  assign r5  = r_c[5];
  assign r6  = r_c[6];
  assign r7  = r_c[7];
  assign r8  = r_c[8];
  assign r9  = r_c[9];
  assign r10 = r_c[10];
  assign r11 = r_c[11];
  assign r12 = r_c[12];
  assign r13 = r_c[13];
  assign r14 = r_c[14];
  assign r15 = r_c[15];
  assign r16 = r_c[16];
  assign r17 = r_c[17];
  assign r18 = r_c[18];
  assign r19 = r_c[19];
  assign r20 = r_c[20];
  assign r21 = r_c[21];
  assign r22 = r_c[22];
  assign r23 = r_c[23];
  assign r24 = r_c[24];
  assign r25 = r_c[25];
  assign r26 = r_c[26];
  assign r27 = r_c[27];
  assign r28 = r_c[28];
  assign r29 = r_c[29];
  assign r30 = r_c[30];
  assign r31 = r_c[31];

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Bench for reg_bank_32x32: directed scenarios plus random traffic, checked
// every cycle against an array-based model of the register file and scoreboard.
module tb_reg_bank_32x32;
  import ezrisc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic [31:0] dut_r [32];

  logic [31:0] m_r [32];
  logic        m_busy [32];
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  reg_bank_32x32 dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .r0(dut_r[0]),   .r1(dut_r[1]),   .r2(dut_r[2]),   .r3(dut_r[3]),
    .r4(dut_r[4]),   .r5(dut_r[5]),   .r6(dut_r[6]),   .r7(dut_r[7]),
    .r8(dut_r[8]),   .r9(dut_r[9]),   .r10(dut_r[10]), .r11(dut_r[11]),
    .r12(dut_r[12]), .r13(dut_r[13]), .r14(dut_r[14]), .r15(dut_r[15]),
    .r16(dut_r[16]), .r17(dut_r[17]), .r18(dut_r[18]), .r19(dut_r[19]),
    .r20(dut_r[20]), .r21(dut_r[21]), .r22(dut_r[22]), .r23(dut_r[23]),
    .r24(dut_r[24]), .r25(dut_r[25]), .r26(dut_r[26]), .r27(dut_r[27]),
    .r28(dut_r[28]), .r29(dut_r[29]), .r30(dut_r[30]), .r31(dut_r[31]),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: architectural state after each edge, following the write/scoreboard rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 32; n++) begin
        m_r[n] = 32'h0;
        m_busy[n] = 1'b0;
      end
    end else begin
      if (wb_valid && wb_rd != 5'd0) begin
        m_r[wb_rd] = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) begin
        m_busy[issue_rd] = 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_r(input int n);
    logic [31:0] v;
    v = m_r[n];
`ifdef REG_BANK_WB_BYPASS_EN
    if (wb_valid && n != 0 && wb_rd == 5'(n)) v = wb_data;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    for (int n = 0; n < 32; n++) b[n] = m_busy[n];
    return b;
  endfunction

  // Per-cycle comparison, mid-cycle so inputs and outputs have settled.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int n = 0; n < 32; n++) chk($sformatf("r%0d", n), dut_r[n], exp_r(n));
      chk("busy", busy, exp_busy());
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic iv, input logic [4:0] ird);
    wb_valid = v; wb_rd = rd; wb_data = d; issue_valid = iv; issue_rd = ird;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; issue_valid = 1'b0; issue_rd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    next_edge();
  endtask

  initial begin
    logic [31:0] lit;
    do_reset();
    chk_en = 1'b1;

    drive(0, 0, 0, 0, 0);
    chk("reset_busy", busy, 32'h0);
    chk("reset_r5", dut_r[5], 32'h0);
    next_edge();

    // r5 write: visible next cycle (or same cycle with bypass)
    drive(1, 5, 32'hDEADBEEF, 0, 0);
`ifdef REG_BANK_WB_BYPASS_EN
    lit = 32'hDEADBEEF;
`else
    lit = 32'h0;
`endif
    chk("r5_write_cycle", dut_r[5], lit);
    next_edge();
    drive(0, 0, 0, 0, 0);
    chk("r5_after", dut_r[5], 32'hDEADBEEF);
    chk("r6_untouched", dut_r[6], 32'h0);
    next_edge();

    // writes to r0 are dropped
    drive(1, 0, 32'hFFFFFFFF, 1, 0);
    chk("r0_bypass_zero", dut_r[0], 32'h0);
    next_edge();
    drive(0, 0, 0, 0, 0);
    chk("r0_zero", dut_r[0], 32'h0);
    chk("busy0_zero", {31'h0, busy[0]}, 32'h0);
    next_edge();

    // issue r7, write back two cycles later
    drive(0, 0, 0, 1, 7);
    next_edge();
    drive(0, 0, 0, 0, 0);
    chk("busy7_c1", {31'h0, busy[7]}, 32'h1);
    next_edge();
    drive(1, 7, 32'h12345678, 0, 0);
    chk("busy7_c2", {31'h0, busy[7]}, 32'h1);
    next_edge();
    drive(0, 0, 0, 0, 0);
    chk("busy7_clear", {31'h0, busy[7]}, 32'h0);
    chk("r7_val", dut_r[7], 32'h12345678);
    next_edge();

    // same-cycle issue and write-back of a busy register: set wins
    drive(0, 0, 0, 1, 9);
    next_edge();
    drive(1, 9, 32'hA5A5A5A5, 1, 9);
    next_edge();
    drive(0, 0, 0, 0, 0);
    chk("r9_val", dut_r[9], 32'hA5A5A5A5);
    chk("busy9_stays", {31'h0, busy[9]}, 32'h1);
    next_edge();

    // back-to-back writes, no cross-register disturbance
    drive(1, 3, 32'h1, 0, 0); next_edge();
    drive(1, 4, 32'h2, 0, 0); next_edge();
    drive(1, 3, 32'h3, 0, 0); next_edge();
    drive(0, 0, 0, 0, 0);
    chk("r3_final", dut_r[3], 32'h3);
    chk("r4_final", dut_r[4], 32'h2);
    next_edge();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom));
      next_edge();
    end

    // fill all registers, then reset mid-cycle
    for (int n = 1; n < 32; n++) begin
      drive(1, 5'(n), 32'h100 + 32'(n), 0, 0);
      next_edge();
    end
    drive(0, 0, 0, 1, 12);
    chk("r31_fill", dut_r[31], 32'h11F);
    chk("r1_fill", dut_r[1], 32'h101);
    next_edge();
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int n = 0; n < 32; n++) chk($sformatf("rst_r%0d", n), dut_r[n], 32'h0);
    chk("rst_busy", busy, 32'h0);
    do_reset();
    chk_en = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("post_rst_r12", dut_r[12], 32'h0);
    next_edge();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
